// File: rtl/multi_filter_div_pkg.sv
// Shared widths and FSM encoding for the multi_filter normalising divider.
package multi_filter_div_pkg;

    localparam int DIVIDEND_W_DEF = 17;
    localparam int DIVISOR_W_DEF  = 10;
    localparam int CNT_W_DEF      = $clog2(DIVIDEND_W_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/multi_filter_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and try
// subtracting the divisor. The subtraction is one bit wider than the partial
// remainder so its top bit is a clean borrow flag.
module multi_filter_div_step #(
    parameter int DIVISOR_W = multi_filter_div_pkg::DIVISOR_W_DEF
) (
    input  logic [DIVISOR_W:0]   rem,
    input  logic                 quot_msb,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   next_rem,
    output logic                 q_bit
);

    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] diff;

    // Trial subtraction; keep the shifted value when it borrows (restore).
    always_comb begin
        shifted  = {rem, quot_msb};
        diff     = shifted - {2'b00, divisor};
        q_bit    = ~diff[DIVISOR_W+1];
        next_rem = q_bit ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];
    end

endmodule

// File: rtl/multi_filter_udiv_17ns_10ns_seq.sv
// Sequential unsigned restoring divider normalising the filter's kernel sum.
// Handshake: a transfer happens on any rising edge where valid & ready are
// both high; valid, once raised, holds its payload stable until that edge.
// One division in flight; in_ready is high only in IDLE.
module multi_filter_udiv_17ns_10ns_seq
    import multi_filter_div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] in_dividend,
    input  logic [DIVISOR_W-1:0]  in_divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] out_quotient,
    output logic [DIVISOR_W-1:0]  out_remainder,
    output logic                  out_div_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    div_state_e            state_q, state_d;
    logic [DIVISOR_W:0]    rem_q, rem_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DIVIDEND_W-1:0] out_quotient_q, out_quotient_d;
    logic [DIVISOR_W-1:0]  out_remainder_q, out_remainder_d;
    logic                  out_div_zero_q, out_div_zero_d;

    logic [DIVISOR_W:0]    step_rem;
    logic                  step_q_bit;

    multi_filter_div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem      (rem_q),
        .quot_msb (quot_q[DIVIDEND_W-1]),
        .divisor  (divisor_q),
        .next_rem (step_rem),
        .q_bit    (step_q_bit)
    );

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = out_valid_q;
    assign out_quotient  = out_quotient_q;
    assign out_remainder = out_remainder_q;
    assign out_div_zero  = out_div_zero_q;

    // Next-state logic: accept in IDLE, iterate in BUSY, hold the result in DONE.
    always_comb begin
        state_d         = state_q;
        rem_d           = rem_q;
        quot_d          = quot_q;
        divisor_d       = divisor_q;
        cnt_d           = cnt_q;
        out_valid_d     = out_valid_q;
        out_quotient_d  = out_quotient_q;
        out_remainder_d = out_remainder_q;
        out_div_zero_d  = out_div_zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    quot_d    = in_dividend;
                    divisor_d = in_divisor;
                    rem_d     = '0;
                    cnt_d     = CNT_W'(DIVIDEND_W);
                    if (in_divisor == '0) begin
                        // Divide by zero short-circuits straight to a saturated result.
                        state_d         = DONE;
                        out_valid_d     = 1'b1;
                        out_quotient_d  = '1;
                        out_remainder_d = '0;
                        out_div_zero_d  = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                quot_d = {quot_q[DIVIDEND_W-2:0], step_q_bit};
                rem_d  = step_rem;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Last iteration: publish the finished quotient/remainder.
                    state_d         = DONE;
                    out_valid_d     = 1'b1;
                    out_quotient_d  = {quot_q[DIVIDEND_W-2:0], step_q_bit};
                    out_remainder_d = step_rem[DIVISOR_W-1:0];
                    out_div_zero_d  = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight division.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q         <= IDLE;
            rem_q           <= '0;
            quot_q          <= '0;
            divisor_q       <= '0;
            cnt_q           <= '0;
            out_valid_q     <= 1'b0;
            out_quotient_q  <= '0;
            out_remainder_q <= '0;
            out_div_zero_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            rem_q           <= rem_d;
            quot_q          <= quot_d;
            divisor_q       <= divisor_d;
            cnt_q           <= cnt_d;
            out_valid_q     <= out_valid_d;
            out_quotient_q  <= out_quotient_d;
            out_remainder_q <= out_remainder_d;
            out_div_zero_q  <= out_div_zero_d;
        end
    end

endmodule
